// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds RV32I opcode constants, FSM state encoding and operand-use decode.
package hazard_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    function automatic logic uses_rs1(input logic [6:0] op);
        return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, clear (wins over inc), inc, count (sticks at all-ones).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: load-use stalls,
// branch flushes, data-memory wait freeze, watchdog and perf counters.
// Inputs: ID operand fields/opcode, EX rd/load/redirect, MEM request/ready.
// Outputs: PC/pipeline-register write, flush and bubble enables,
// sticky TIMEOUT_ERR, saturating STALL_CNT and FLUSH_CNT.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       RS1_ID,
    input  logic [4:0]       RS2_ID,
    input  logic [6:0]       OPCODE_ID,
    input  logic [4:0]       RD_EX,
    input  logic             MemRead_EX,
    input  logic             PCSrc_EX,
    input  logic             MEM_REQ_MEM,
    input  logic             MEM_READY,
    output logic             PC_WRITE,
    output logic             IF_ID_WRITE,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_WRITE,
    output logic             ID_EX_FLUSH,
    output logic             EX_MEM_WRITE,
    output logic             MEM_WB_BUBBLE,
    output logic             TIMEOUT_ERR,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] TMO      = WW'(MEM_TIMEOUT);
    localparam logic [WW-1:0] TMO_LAST = WW'(MEM_TIMEOUT - 1);

    logic [0:0]    state;
    logic [WW-1:0] wait_cnt;
    logic          mem_wait;
    logic          load_use;
    logic          stall_inc;
    logic          flush_inc;

    // Freeze is decided combinationally so it covers the first wait cycle,
    // before the FSM has registered MEM_WAIT.
    assign mem_wait = MEM_REQ_MEM && !MEM_READY;

    assign load_use = MemRead_EX && (RD_EX != 5'd0) &&
                      ((uses_rs1(OPCODE_ID) && (RD_EX == RS1_ID)) ||
                       (uses_rs2(OPCODE_ID) && (RD_EX == RS2_ID)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            unique case (state)
                ST_RUN:      if (mem_wait) state <= ST_MEM_WAIT;
                ST_MEM_WAIT: if (MEM_READY) state <= ST_RUN;
                default:     state <= ST_RUN;
            endcase
            if (mem_wait) begin
                if (wait_cnt != TMO) wait_cnt <= wait_cnt + 1'b1;
                // Sticky: only reset clears it; the freeze itself goes on.
                if (wait_cnt >= TMO_LAST) TIMEOUT_ERR <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        PC_WRITE      = 1'b1;
        IF_ID_WRITE   = 1'b1;
        IF_ID_FLUSH   = 1'b0;
        ID_EX_WRITE   = 1'b1;
        ID_EX_FLUSH   = 1'b0;
        EX_MEM_WRITE  = 1'b1;
        MEM_WB_BUBBLE = 1'b0;
        if (reset) begin
            PC_WRITE      = 1'b0;
            IF_ID_WRITE   = 1'b0;
            IF_ID_FLUSH   = 1'b1;
            ID_EX_FLUSH   = 1'b1;
            MEM_WB_BUBBLE = 1'b1;
        end else if (mem_wait) begin
            // Branch/hazard are deferred; they re-evaluate after unfreeze.
            PC_WRITE      = 1'b0;
            IF_ID_WRITE   = 1'b0;
            ID_EX_WRITE   = 1'b0;
            EX_MEM_WRITE  = 1'b0;
            MEM_WB_BUBBLE = 1'b1;
        end else if (PCSrc_EX) begin
            // ID holds a wrong-path instruction, so its hazard is moot.
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
        end else if (load_use) begin
            PC_WRITE    = 1'b0;
            IF_ID_WRITE = 1'b0;
            ID_EX_FLUSH = 1'b1;
        end
    end

    assign stall_inc = !reset && (mem_wait || (!PCSrc_EX && load_use));
    assign flush_inc = !reset && !mem_wait && PCSrc_EX;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (stall_inc),
        .count (STALL_CNT)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (flush_inc),
        .count (FLUSH_CNT)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, corner sequences
// and random stimulus against a behavioural reference model.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int TMO_A = 4;
    localparam int TMO_B = 64;
    localparam int W_A   = 16;
    localparam int W_B   = 2;

    localparam logic [6:0] O_RST  = 7'b0011111;
    localparam logic [6:0] O_WAIT = 7'b0000001;
    localparam logic [6:0] O_BR   = 7'b1111110;
    localparam logic [6:0] O_LU   = 7'b0001110;
    localparam logic [6:0] O_NORM = 7'b1101010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] rs1, rs2, rd;
    logic [6:0] op;
    logic       mr, pcsrc, req, rdy;

    logic pcw_a, ifw_a, iff_a, idw_a, idf_a, exw_a, bub_a, err_a;
    logic pcw_b, ifw_b, iff_b, idw_b, idf_b, exw_b, bub_b, err_b;
    logic [W_A-1:0] stall_a, flush_a;
    logic [W_B-1:0] stall_b, flush_b;
    logic [6:0] outs_a, outs_b;

    assign outs_a = {pcw_a, ifw_a, iff_a, idw_a, idf_a, exw_a, bub_a};
    assign outs_b = {pcw_b, ifw_b, iff_b, idw_b, idf_b, exw_b, bub_b};

    hazard_ctrl #(.MEM_TIMEOUT(TMO_A), .CNT_W(W_A)) dut (
        .clk(clk), .reset(reset), .RS1_ID(rs1), .RS2_ID(rs2),
        .OPCODE_ID(op), .RD_EX(rd), .MemRead_EX(mr), .PCSrc_EX(pcsrc),
        .MEM_REQ_MEM(req), .MEM_READY(rdy),
        .PC_WRITE(pcw_a), .IF_ID_WRITE(ifw_a), .IF_ID_FLUSH(iff_a),
        .ID_EX_WRITE(idw_a), .ID_EX_FLUSH(idf_a), .EX_MEM_WRITE(exw_a),
        .MEM_WB_BUBBLE(bub_a), .TIMEOUT_ERR(err_a),
        .STALL_CNT(stall_a), .FLUSH_CNT(flush_a)
    );

    hazard_ctrl #(.MEM_TIMEOUT(TMO_B), .CNT_W(W_B)) dut_s (
        .clk(clk), .reset(reset), .RS1_ID(rs1), .RS2_ID(rs2),
        .OPCODE_ID(op), .RD_EX(rd), .MemRead_EX(mr), .PCSrc_EX(pcsrc),
        .MEM_REQ_MEM(req), .MEM_READY(rdy),
        .PC_WRITE(pcw_b), .IF_ID_WRITE(ifw_b), .IF_ID_FLUSH(iff_b),
        .ID_EX_WRITE(idw_b), .ID_EX_FLUSH(idf_b), .EX_MEM_WRITE(exw_b),
        .MEM_WB_BUBBLE(bub_b), .TIMEOUT_ERR(err_b),
        .STALL_CNT(stall_b), .FLUSH_CNT(flush_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: unbounded event counts, saturated when compared.
    int m_stall, m_flush, m_run;
    bit m_err_a, m_err_b;

    typedef struct {
        logic       rst;
        logic [4:0] rs1, rs2;
        logic [6:0] op;
        logic [4:0] rd;
        logic       mr, pc, req, rdy;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[14];

    function automatic logic ref_lu();
        bit r1, r2;
        r1 = !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
        r2 = op inside {OP_R, OP_STORE, OP_BRANCH};
        return mr && rd != 0 && ((r1 && rd == rs1) || (r2 && rd == rs2));
    endfunction

    function automatic logic [6:0] ref_out();
        if (reset) return O_RST;
        if (req && !rdy) return O_WAIT;
        if (pcsrc) return O_BR;
        if (ref_lu()) return O_LU;
        return O_NORM;
    endfunction

    function automatic int sat(input int x, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (x > mx) ? mx : x;
    endfunction

    function automatic vec_t mk(input logic r, input logic [4:0] a,
        input logic [4:0] b, input logic [6:0] o, input logic [4:0] d,
        input logic m, input logic p, input logic q, input logic y,
        input logic [6:0] e);
        vec_t v;
        v.rst = r; v.rs1 = a; v.rs2 = b; v.op = o; v.rd = d;
        v.mr = m; v.pc = p; v.req = q; v.rdy = y; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [4:0] a,
        input logic [4:0] b, input logic [6:0] o, input logic [4:0] d,
        input logic m, input logic p, input logic q, input logic y);
        reset = r; rs1 = a; rs2 = b; op = o; rd = d;
        mr = m; pcsrc = p; req = q; rdy = y;
    endtask

    task automatic idle();
        drive(0, 0, 0, OP_I, 0, 0, 0, 0, 0);
    endtask

    task automatic cycle(input bit use_t, input logic [6:0] t_exp);
        bit w;
        @(negedge clk);
        if (use_t) chk("table", 32'(outs_a), 32'(t_exp));
        chk("outs", 32'(outs_a), 32'(ref_out()));
        chk("outs_s", 32'(outs_b), 32'(ref_out()));
        chk("err", 32'(err_a), 32'(m_err_a));
        chk("err_s", 32'(err_b), 32'(m_err_b));
        chk("stall", 32'(stall_a), 32'(sat(m_stall, W_A)));
        chk("flush", 32'(flush_a), 32'(sat(m_flush, W_A)));
        chk("stall_s", 32'(stall_b), 32'(sat(m_stall, W_B)));
        chk("flush_s", 32'(flush_b), 32'(sat(m_flush, W_B)));
        @(posedge clk);
        w = req && !rdy;
        if (reset) begin
            m_stall = 0; m_flush = 0; m_run = 0;
            m_err_a = 0; m_err_b = 0;
        end else if (w) begin
            m_stall++;
            m_run++;
            if (m_run >= TMO_A) m_err_a = 1;
            if (m_run >= TMO_B) m_err_b = 1;
        end else begin
            m_run = 0;
            if (pcsrc) m_flush++;
            else if (ref_lu()) m_stall++;
        end
        #1;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, OP_R, 0, 0, 0, 0, 0);
        cycle(1, O_RST);
        cycle(1, O_RST);
        idle();
    endtask

    initial begin
        m_stall = 0; m_flush = 0; m_run = 0; m_err_a = 0; m_err_b = 0;
        drive(1, 0, 0, OP_R, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        do_reset();
        chk("rst_err", 32'(err_a), 0);
        chk("rst_stall", 32'(stall_a), 0);
        chk("rst_flush", 32'(flush_a), 0);

        tbl[0]  = mk(0, 5, 7, OP_R,      5, 1, 0, 0, 0, O_LU);
        tbl[1]  = mk(0, 0, 3, OP_R,      0, 1, 0, 0, 0, O_NORM);
        tbl[2]  = mk(0, 5, 0, OP_LUI,    5, 1, 0, 0, 0, O_NORM);
        tbl[3]  = mk(0, 5, 0, OP_AUIPC,  5, 1, 0, 0, 0, O_NORM);
        tbl[4]  = mk(0, 5, 7, OP_R,      5, 1, 1, 0, 0, O_BR);
        tbl[5]  = mk(0, 1, 9, OP_STORE,  9, 1, 0, 0, 0, O_LU);
        tbl[6]  = mk(0, 1, 9, OP_I,      9, 1, 0, 0, 0, O_NORM);
        tbl[7]  = mk(0, 4, 4, OP_BRANCH, 4, 0, 0, 0, 0, O_NORM);
        tbl[8]  = mk(0, 5, 7, OP_R,      5, 1, 1, 1, 0, O_WAIT);
        tbl[9]  = mk(0, 5, 7, OP_R,      5, 1, 0, 1, 1, O_LU);
        tbl[10] = mk(0, 6, 0, OP_JAL,    6, 1, 0, 0, 0, O_NORM);
        tbl[11] = mk(0, 6, 0, OP_JALR,   6, 1, 0, 0, 0, O_LU);
        tbl[12] = mk(0, 2, 8, OP_BRANCH, 8, 1, 0, 0, 0, O_LU);
        tbl[13] = mk(1, 5, 7, OP_R,      5, 1, 1, 1, 0, O_RST);
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rst, tbl[i].rs1, tbl[i].rs2, tbl[i].op, tbl[i].rd,
                  tbl[i].mr, tbl[i].pc, tbl[i].req, tbl[i].rdy);
            cycle(1, tbl[i].exp);
        end

        // Load-use: one stall, counter 0 -> 1, then free flow.
        do_reset();
        drive(0, 5, 7, OP_R, 5, 1, 0, 0, 0);
        cycle(1, O_LU);
        chk("lu_stall", 32'(stall_a), 1);
        idle();
        cycle(1, O_NORM);
        // False hazards leave the stall count unchanged.
        drive(0, 0, 0, OP_R, 0, 1, 0, 0, 0);
        cycle(1, O_NORM);
        drive(0, 5, 0, OP_LUI, 5, 1, 0, 0, 0);
        cycle(1, O_NORM);
        chk("false_stall", 32'(stall_a), 1);

        // Branch beats a simultaneous load-use.
        do_reset();
        drive(0, 5, 7, OP_R, 5, 1, 1, 0, 0);
        cycle(1, O_BR);
        chk("br_flush", 32'(flush_a), 1);
        chk("br_stall", 32'(stall_a), 0);

        // Three-cycle memory wait.
        do_reset();
        drive(0, 0, 0, OP_I, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(1, O_WAIT);
        drive(0, 0, 0, OP_I, 0, 0, 0, 1, 1);
        cycle(1, O_NORM);
        chk("mw_stall", 32'(stall_a), 3);
        chk("mw_err", 32'(err_a), 0);
        idle();
        cycle(1, O_NORM);

        // Watchdog fires after the 4th wait cycle and is sticky.
        do_reset();
        drive(0, 0, 0, OP_I, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(1, O_WAIT);
        chk("wd_early", 32'(err_a), 0);
        cycle(1, O_WAIT);
        chk("wd_fire", 32'(err_a), 1);
        drive(0, 0, 0, OP_I, 0, 0, 0, 1, 1);
        cycle(1, O_NORM);
        chk("wd_sticky", 32'(err_a), 1);
        drive(1, 0, 0, OP_I, 0, 0, 0, 0, 0);
        cycle(1, O_RST);
        chk("wd_clr", 32'(err_a), 0);
        chk("wd_stall0", 32'(stall_a), 0);
        chk("wd_flush0", 32'(flush_a), 0);

        // Saturation of the 2-bit counter.
        do_reset();
        drive(0, 3, 3, OP_R, 3, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, O_LU);
        chk("sat_s", 32'(stall_b), 3);
        chk("sat_wide", 32'(stall_a), 5);

        for (int i = 0; i < 3000; i++) begin
            logic [6:0] ops[10];
            ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, 7'b1110011};
            drive(($urandom_range(0, 63) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ops[$urandom_range(0, 9)], 5'($urandom_range(0, 3)),
                  1'($urandom), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 2) == 0), 1'($urandom));
            cycle(0, 7'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core.
- Sits beside the IF/ID/EX/MEM stages and drives the stall, flush and freeze enables of the PC and the pipeline registers.
- Resolves load-use hazards, taken-branch/jump flushes and multi-cycle data-memory waits, with a timeout watchdog and saturating stall/flush counters.

Parameters:
- MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before TIMEOUT_ERR is raised.
- CNT_W, 16, width of the STALL_CNT and FLUSH_CNT performance counters.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- RS1_ID  input  5  rs1 field of the instruction in ID.
- RS2_ID  input  5  rs2 field of the instruction in ID.
- OPCODE_ID  input  7  opcode of the instruction in ID.
- RD_EX  input  5  destination register of the instruction in EX.
- MemRead_EX  input  1  instruction in EX is a load.
- PCSrc_EX  input  1  branch taken / jump resolved in EX this cycle.
- MEM_REQ_MEM  input  1  MEM stage holds a valid data-memory access.
- MEM_READY  input  1  data memory completes the access this cycle.
- PC_WRITE  output  1  PC update enable.
- IF_ID_WRITE  output  1  IF/ID register load enable.
- IF_ID_FLUSH  output  1  IF/ID loads a NOP.
- ID_EX_WRITE  output  1  ID/EX register load enable.
- ID_EX_FLUSH  output  1  ID/EX loads a bubble (control bits zero).
- EX_MEM_WRITE  output  1  EX/MEM register load enable.
- MEM_WB_BUBBLE  output  1  MEM/WB loads a bubble (RegWrite=0).
- TIMEOUT_ERR  output  1  sticky watchdog error.
- STALL_CNT  output  CNT_W  saturating count of stall cycles (load-use plus memory wait).
- FLUSH_CNT  output  CNT_W  saturating count of flush events.

Behaviour:
- Operand use decode:
  - uses_rs1 = 0 for LUI 0110111, AUIPC 0010111 and JAL 1101111; 1 for all other opcodes.
  - uses_rs2 = 1 only for 0110011 (R-type), 0100011 (store) and 1100011 (branch).
- Load-use hazard: MemRead_EX && RD_EX!=0 && ((uses_rs1 && RD_EX==RS1_ID) || (uses_rs2 && RD_EX==RS2_ID)).
- FSM states:
  - RUN → MEM_WAIT when MEM_REQ_MEM && !MEM_READY.
  - MEM_WAIT → RUN on the first MEM_READY cycle.
  - State is registered; the wait condition is also evaluated combinationally so the freeze applies in the first wait cycle.
- Output priority (combinational, evaluated in this order):
  1. reset=1: PC_WRITE=0, IF_ID_WRITE=0, IF_ID_FLUSH=1, ID_EX_FLUSH=1, MEM_WB_BUBBLE=1, all other enables 1.
  2. Memory wait (MEM_REQ_MEM && !MEM_READY): PC_WRITE, IF_ID_WRITE, ID_EX_WRITE and EX_MEM_WRITE all 0; MEM_WB_BUBBLE=1; no flushes. Any branch or hazard in this cycle is deferred: it is re-evaluated when the pipeline unfreezes.
  3. PCSrc_EX=1: PC_WRITE=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1. A simultaneous load-use hazard is ignored because the ID instruction is wrong-path.
  4. Load-use: PC_WRITE=0, IF_ID_WRITE=0, ID_EX_FLUSH=1. Exactly 1 stall cycle, since the load leaves EX next cycle.
  5. Otherwise: all write enables 1, all flushes and bubbles 0.
- Watchdog:
  - Wait counter clears in RUN and increments each MEM_WAIT cycle.
  - When it reaches MEM_TIMEOUT, TIMEOUT_ERR is set. It stays set until reset; the freeze continues.
- Counters:
  - STALL_CNT += 1 on every memory-wait or load-use cycle.
  - FLUSH_CNT += 1 on every PCSrc_EX cycle taken at priority 3.
  - Both saturate at all-ones and are cleared by reset.
- Reset values: state RUN, wait counter 0, TIMEOUT_ERR 0, STALL_CNT 0, FLUSH_CNT 0. Reset asserted mid-wait returns the FSM to RUN on the next edge.

Decomposition:
- Shared package holds:
  - Opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
  - FSM state encoding: ST_RUN, ST_MEM_WAIT.
- One natural sub-module: sat_counter (parameterised width, inc, clear), instantiated twice.

Test Plan:
- Load-use: lw x5 in EX (RD_EX=5, MemRead_EX=1) with add x6,x5,x7 in ID → one cycle of PC_WRITE=0, IF_ID_WRITE=0, ID_EX_FLUSH=1; STALL_CNT 0→1; next cycle all enables 1.
- False hazards: RD_EX=0 with RS1_ID=0; also LUI in ID with RS1 field=5 and RD_EX=5 → no stall; STALL_CNT unchanged.
- Branch vs. hazard: PCSrc_EX=1 in the same cycle as a load-use match → IF_ID_FLUSH=1, ID_EX_FLUSH=1, PC_WRITE=1; FLUSH_CNT=1, STALL_CNT=0.
- Memory wait: MEM_REQ_MEM=1, MEM_READY=0 for 3 cycles, then 1 → 3 freeze cycles (all write enables 0, MEM_WB_BUBBLE=1); STALL_CNT=3; FSM back in RUN.
- Watchdog: MEM_TIMEOUT=4 with MEM_READY held 0 → TIMEOUT_ERR rises after the 4th wait cycle and stays 1 after MEM_READY=1; a reset pulse clears it, and both counters read 0.
- Saturation: CNT_W=2 with 5 load-use cycles → STALL_CNT sticks at 3.
